// File: rtl/store_buffer.sv
// store_buffer: MEM-stage store FIFO feeding DataMemory, with load lookup and port ownership.
// Define STORE_BUF_FWD_EN to forward exact-match buffered data to loads; otherwise overlapping loads stall and drain.
// ONE_OP_CHECK=0 silences the same-cycle store+load assertion for environments that drive both on purpose.
module store_buffer #(
    parameter int DEPTH        = 4,
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter bit ONE_OP_CHECK = 1'b1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              St_Valid,
    input  logic [ADDR_W-1:0] St_Addr,
    input  logic [DATA_W-1:0] St_Data,
    output logic              St_Ready,
    input  logic              Ld_Valid,
    input  logic [ADDR_W-1:0] Ld_Addr,
    output logic [DATA_W-1:0] Ld_Data,
    output logic              Ld_Hit,
    output logic              Ld_Stall,
    output logic              Empty,
    output logic              Mem_MemWre,
    output logic              Mem_MemRead,
    output logic [ADDR_W-1:0] Mem_DataAddress,
    output logic [DATA_W-1:0] Mem_DataIn,
    input  logic [DATA_W-1:0] Mem_DataOut
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [PW-1:0]     head, tail;
    logic [CW-1:0]     count;
    logic              full, push, drain, exact, part;
    logic [DATA_W-1:0] fwd_data;

    assign full  = count == CW'(DEPTH);
    assign push  = St_Valid & ~full;
    assign Empty = count == '0;
    assign St_Ready = ~full;

    // Walk valid entries oldest to youngest: the last exact match is the youngest, and an exact match hides older partial overlaps
    always_comb begin
        logic [PW-1:0]     idx;
        logic [ADDR_W-1:0] d;
        exact    = 1'b0;
        part     = 1'b0;
        fwd_data = '0;
        idx      = head;
        d        = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            d   = Ld_Addr - addr_q[idx];
            if (i < int'(count)) begin
                if (d == '0) begin
                    exact    = 1'b1;
                    part     = 1'b0;
                    fwd_data = data_q[idx];
                end else if (d < ADDR_W'(4) || (ADDR_W'(0) - d) < ADDR_W'(4)) begin
                    part = 1'b1;
                end
            end
        end
    end

`ifdef STORE_BUF_FWD_EN
    // A partially overlapping load can only complete once the entry has left, so it also claims the port for draining
    assign Ld_Hit   = Ld_Valid & exact;
    assign Ld_Stall = Ld_Valid & (part | (full & ~exact));
    assign drain    = ~Empty & (~Ld_Valid | full | part);
`else
    assign Ld_Hit   = 1'b0;
    assign Ld_Stall = Ld_Valid & (exact | part | full);
    assign drain    = ~Empty & (~Ld_Valid | full | exact | part);
`endif

    assign Ld_Data         = Ld_Hit ? fwd_data : Mem_DataOut;
    assign Mem_MemWre      = drain;
    assign Mem_MemRead     = Ld_Valid & ~drain & ~Ld_Hit & ~Ld_Stall;
    assign Mem_DataAddress = drain ? addr_q[head] : Ld_Addr;
    assign Mem_DataIn      = data_q[head];

    // Pointers and occupancy; reset discards anything still pending
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + PW'(1);
            if (drain) head <= head + PW'(1);
            count <= count + CW'(push) - CW'(drain);
        end
    end

    // Entry storage needs no reset: only entries below count are ever looked at
    always_ff @(posedge Clk) begin
        if (push) begin
            addr_q[tail] <= St_Addr;
            data_q[tail] <= St_Data;
        end
    end

    // Only one MEM-stage operation may be presented per cycle
    a_one_op: assert property (@(posedge Clk) disable iff (!Reset) !(ONE_OP_CHECK && St_Valid && Ld_Valid));

endmodule
